// File: rtl/audio_mix_pkg.sv
// audio_mix_pkg: shared constants and width helper for audio_mix_dac
package audio_mix_pkg;
  localparam int GAIN_FRAC  = 3;
  localparam int GAIN_UNITY = 8;
  localparam int DCB_SHIFT  = 8;
  function automatic int sum_width(input int nch, input int in_w, input int gain_w);
    return in_w + gain_w - GAIN_FRAC + $clog2(nch);
  endfunction
endpackage

// File: rtl/audio_mix_dac_sd_dac1.sv
// sd_dac1: first-order sigma-delta 1-bit DAC, carry of the accumulator is the output bit
module sd_dac1 #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic         o_bit
);
  logic [W-1:0] r_acc;
  logic [W:0]   w_nxt;
  assign w_nxt = {1'b0, r_acc} + {1'b0, i_d};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      o_bit <= 1'b0;
    end else begin
      r_acc <= w_nxt[W-1:0];
      o_bit <= w_nxt[W];
    end
  end
endmodule

// File: rtl/audio_mix_dac.sv
// audio_mix_dac: N-channel gain/mix/saturate pipeline feeding a 1-bit sigma-delta DAC.
// Define AUDIO_MIX_DC_BLOCK_EN to add a DC-blocking high-pass output stage (latency 4 instead of 3).
module audio_mix_dac
  import audio_mix_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int IN_W   = 14,
  parameter int GAIN_W = 4,
  parameter int OUT_W  = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ce_sample,
  input  logic [NCH*IN_W-1:0]     ch_data,
  input  logic [NCH-1:0]          ch_en,
  input  logic [NCH*GAIN_W-1:0]   ch_gain,
  input  logic                    clip_clr,
  output logic [OUT_W-1:0]        sample_out,
  output logic [OUT_W-1:0]        sample_s,
  output logic                    sample_valid,
  output logic                    clip,
  output logic                    dac_o
);
  localparam int P_W   = IN_W + GAIN_W - GAIN_FRAC;
  localparam int SUM_W = sum_width(NCH, IN_W, GAIN_W);
  localparam int M_W   = SUM_W > OUT_W ? SUM_W : OUT_W;
  logic [NCH-1:0][P_W-1:0] w_p, r_p;
  logic [SUM_W-1:0]        w_sum, r_sum;
  logic [M_W-1:0]          w_sum_x;
  logic                    w_sat;
  logic [OUT_W-1:0]        w_mix, r_sample;
  logic                    r_v1, r_v2, r_valid, r_clip;
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [IN_W+GAIN_W-1:0] w_prod;
    assign w_prod = (IN_W+GAIN_W)'(ch_data[k*IN_W +: IN_W]) * (IN_W+GAIN_W)'(ch_gain[k*GAIN_W +: GAIN_W]);
    assign w_p[k] = ch_en[k] ? P_W'(w_prod >> GAIN_FRAC) : '0;
  end
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NCH; i++) w_sum = w_sum + SUM_W'(r_p[i]);
  end
  assign w_sum_x = M_W'(r_sum);
  assign w_sat   = w_sum_x > M_W'({OUT_W{1'b1}});
  assign w_mix   = w_sat ? '1 : w_sum_x[OUT_W-1:0];
  // Each stage advances only when its valid bit says data is moving, so idle stages hold.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_p    <= '0;
      r_sum  <= '0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_clip <= 1'b0;
    end else begin
      r_v1   <= ce_sample;
      r_v2   <= r_v1;
      if (ce_sample) r_p <= w_p;
      if (r_v1) r_sum <= w_sum;
      r_clip <= (r_v2 & w_sat) | (r_clip & ~clip_clr);
    end
  end
`ifdef AUDIO_MIX_DC_BLOCK_EN
  localparam int F_W = OUT_W + 2;
  logic [OUT_W-1:0]        r_x;
  logic                    r_v3;
  logic signed [F_W-1:0]   w_x, w_y, r_xp, r_yp;
  logic [OUT_W-1:0]        w_ys;
  logic                    w_in_rng;
  // Filter runs in the signed domain, so the unsigned midpoint maps to zero.
  assign w_x      = {{3{~r_x[OUT_W-1]}}, r_x[OUT_W-2:0]};
  assign w_y      = w_x - r_xp + r_yp - (r_yp >>> DCB_SHIFT);
  assign w_in_rng = w_y[F_W-1:OUT_W-1] == '0 || w_y[F_W-1:OUT_W-1] == '1;
  assign w_ys     = w_in_rng ? w_y[OUT_W-1:0] : {w_y[F_W-1], {(OUT_W-1){~w_y[F_W-1]}}};
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_x      <= '0;
      r_v3     <= 1'b0;
      r_xp     <= '0;
      r_yp     <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_v3    <= r_v2;
      r_valid <= r_v3;
      if (r_v2) r_x <= w_mix;
      if (r_v3) begin
        r_xp     <= w_x;
        r_yp     <= {{2{w_ys[OUT_W-1]}}, w_ys};
        r_sample <= {~w_ys[OUT_W-1], w_ys[OUT_W-2:0]};
      end
    end
  end
`else
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= r_v2;
      if (r_v2) r_sample <= w_mix;
    end
  end
`endif
  sd_dac1 #(.W(OUT_W)) u_dac (
    .i_clk (clk_sys),
    .i_rst (reset),
    .i_d   (r_sample),
    .o_bit (dac_o)
  );
  assign sample_out   = r_sample;
  assign sample_s     = {~r_sample[OUT_W-1], r_sample[OUT_W-2:0]};
  assign sample_valid = r_valid;
  assign clip         = r_clip;
endmodule

// File: tb/tb_audio_mix_dac.sv
// tb_audio_mix_dac: directed table-driven bench for audio_mix_dac at default parameters
module tb_audio_mix_dac;
  import audio_mix_pkg::*;
  localparam int NCH = 4, IN_W = 14, GAIN_W = 4, OUT_W = 16, NV = 8;
  logic                  clk_sys = 1'b0, reset = 1'b1, ce_sample = 1'b0, clip_clr = 1'b0;
  logic [NCH*IN_W-1:0]   ch_data = '0;
  logic [NCH-1:0]        ch_en = '0;
  logic [NCH*GAIN_W-1:0] ch_gain = '0;
  logic [OUT_W-1:0]      sample_out, sample_s;
  logic                  sample_valid, clip, dac_o;
  int checks = 0, failures = 0;
  typedef struct {
    string       name;
    logic [55:0] d;
    logic [3:0]  en;
    logic [15:0] g;
    logic [15:0] exp;
    logic        exp_clip;
  } vec_t;
  vec_t v[NV];
  audio_mix_dac #(.NCH(NCH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_sample(ce_sample), .ch_data(ch_data),
    .ch_en(ch_en), .ch_gain(ch_gain), .clip_clr(clip_clr), .sample_out(sample_out),
    .sample_s(sample_s), .sample_valid(sample_valid), .clip(clip), .dac_o(dac_o)
  );
  always #5 clk_sys = ~clk_sys;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic vec_t mk(string n, logic [55:0] d, logic [3:0] en, logic [15:0] g, logic [15:0] e, logic c);
    vec_t r;
    r.name = n; r.d = d; r.en = en; r.g = g; r.exp = e; r.exp_clip = c;
    return r;
  endfunction
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic run_sample(logic [55:0] d, logic [3:0] en, logic [15:0] g);
    ch_data = d; ch_en = en; ch_gain = g; ce_sample = 1'b1;
    tick();
    ce_sample = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    int ones, alt_bad, nvalid;
    logic prev;
    v[0] = mk("unity_ch0",   {14'h1234, 14'h1234, 14'h1234, 14'h3FFF}, 4'b0001, 16'h8888, 16'h3FFF, 1'b0);
    v[1] = mk("four_full",   {4{14'h3FFF}},                            4'b1111, 16'h8888, 16'hFFFC, 1'b0);
    v[2] = mk("four_gain15", {4{14'h3FFF}},                            4'b1111, 16'hFFFF, 16'hFFFF, 1'b1);
    v[3] = mk("gain_zero",   {4{14'h3FFF}},                            4'b1111, 16'h0000, 16'h0000, 1'b0);
    v[4] = mk("mixed",       {14'h0100, 14'h2000, 14'h0003, 14'h1000}, 4'b0111, 16'h8C34, 16'h3801, 1'b0);
    v[5] = mk("edge_ffff",   {14'h0000, 14'h1003, 14'h3FFF, 14'h3FFF}, 4'b0111, 16'h88FF, 16'hFFFF, 1'b0);
    v[6] = mk("edge_10000",  {14'h0000, 14'h1004, 14'h3FFF, 14'h3FFF}, 4'b0111, 16'h88FF, 16'hFFFF, 1'b1);
    v[7] = mk("truncate",    {14'h3FFF, 14'h3FFF, 14'h0007, 14'h0007}, 4'b0011, 16'h0091, 16'h0007, 1'b0);
    tick();
    tick();
    chk("rst_out", 32'(sample_out), 32'h0000);
    chk("rst_s", 32'(sample_s), 32'h8000);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_clip", 32'(clip), 0);
    chk("rst_dac", 32'(dac_o), 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < NV; i++) begin
      run_sample(v[i].d, v[i].en, v[i].g);
      chk({v[i].name, "_valid"}, 32'(sample_valid), 1);
      chk({v[i].name, "_out"}, 32'(sample_out), 32'(v[i].exp));
      chk({v[i].name, "_s"}, 32'(sample_s), 32'(v[i].exp ^ 16'h8000));
      chk({v[i].name, "_clip"}, 32'(clip), 32'(v[i].exp_clip));
      clip_clr = 1'b1;
      tick();
      clip_clr = 1'b0;
      chk({v[i].name, "_pulse"}, 32'(sample_valid), 0);
    end
    chk("clip_cleared", 32'(clip), 0);
    run_sample({4{14'h3FFF}}, 4'b1111, 16'hFFFF);
    chk("sticky_set", 32'(clip), 1);
    run_sample('0, 4'b1111, 16'h8888);
    chk("sticky_zero_out", 32'(sample_out), 0);
    chk("sticky_hold", 32'(clip), 1);
    tick();
    chk("sticky_hold2", 32'(clip), 1);
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    chk("clip_clr", 32'(clip), 0);
    ch_data = {4{14'h3FFF}}; ch_en = 4'b1111; ch_gain = 16'hFFFF; ce_sample = 1'b1;
    tick();
    ce_sample = 1'b0;
    tick();
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    chk("set_wins_clip", 32'(clip), 1);
    chk("set_wins_out", 32'(sample_out), 32'hFFFF);
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    ch_en = 4'b0001; ch_gain = 16'h8888; ce_sample = 1'b1;
    ch_data = {42'h0, 14'h0001};
    tick();
    ch_data = {42'h0, 14'h0002};
    tick();
    ch_data = {42'h0, 14'h0003};
    tick();
    ce_sample = 1'b0;
    chk("b2b_v1", 32'(sample_valid), 1);
    chk("b2b_d1", 32'(sample_out), 1);
    tick();
    chk("b2b_v2", 32'(sample_valid), 1);
    chk("b2b_d2", 32'(sample_out), 2);
    tick();
    chk("b2b_v3", 32'(sample_valid), 1);
    chk("b2b_d3", 32'(sample_out), 3);
    tick();
    chk("b2b_end", 32'(sample_valid), 0);
    run_sample({4{14'h2000}}, 4'b1111, 16'h8888);
    chk("dac_mid_out", 32'(sample_out), 32'h8000);
    for (int i = 0; i < 4; i++) tick();
    ones = 0; alt_bad = 0; prev = dac_o;
    for (int i = 0; i < 256; i++) begin
      tick();
      ones += int'(dac_o);
      if (dac_o == prev) alt_bad++;
      prev = dac_o;
    end
    chk("dac_half_ones", 32'(ones), 128);
    chk("dac_alternate", 32'(alt_bad), 0);
    run_sample('0, 4'b1111, 16'h8888);
    chk("dac_zero_out", 32'(sample_out), 0);
    tick();
    tick();
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      ones += int'(dac_o);
    end
    chk("dac_zero_ones", 32'(ones), 0);
    run_sample({4{14'h3FFF}}, 4'b1111, 16'hFFFF);
    chk("pre_rst_clip", 32'(clip), 1);
    tick();
    ch_data = {4{14'h1555}}; ch_gain = 16'h8888; ce_sample = 1'b1;
    tick();
    ce_sample = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_out", 32'(sample_out), 0);
    chk("mid_rst_s", 32'(sample_s), 32'h8000);
    chk("mid_rst_valid", 32'(sample_valid), 0);
    chk("mid_rst_clip", 32'(clip), 0);
    chk("mid_rst_dac", 32'(dac_o), 0);
    nvalid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvalid += int'(sample_valid);
    end
    chk("mid_rst_no_valid", 32'(nvalid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/audio_mix_dac.md
Name: audio_mix_dac

Overview:
- Parametrised N-channel audio mixer with per-channel enable, gain, saturation and a sticky clip flag.
- Feeds a first-order sigma-delta 1-bit DAC and exposes the mixed PCM word for I2S/SPDIF encoders.
- Replaces the ad-hoc "core audio + tape bits" adder and fixed-width DAC in the MiST top levels.
- Sits between the machine core and the board audio pins.

Parameters:
- NCH, 4, number of input channels (1..8).
- IN_W, 14, width of each unsigned channel sample.
- GAIN_W, 4, per-channel gain width; gain is unsigned fixed-point with 3 fraction bits, so 8 = unity.
- OUT_W, 16, width of the mixed PCM output and the DAC accumulator.

Ports:
- clk_sys  in  1  system clock. The block uses one clock.
- reset  in  1  synchronous, active-high reset.
- ce_sample  in  1  one-cycle sample strobe; input capture happens on this strobe.
- ch_data  in  NCH*IN_W  unsigned samples; channel k is at bits [k*IN_W +: IN_W].
- ch_en  in  NCH  per-channel enable.
- ch_gain  in  NCH*GAIN_W  per-channel gain, packed the same way as ch_data.
- clip_clr  in  1  clears the sticky clip flag.
- sample_out  out  OUT_W  mixed unsigned PCM.
- sample_s  out  OUT_W  two's-complement version: {~sample_out[MSB], sample_out[MSB-1:0]}.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- clip  out  1  sticky saturation indicator.
- dac_o  out  1  sigma-delta bitstream.

Behaviour:
- Reset values: sample_out=0, sample_valid=0, clip=0, dac_o=0, all pipeline registers and the accumulator 0. sample_s therefore resets to 0x8000 for OUT_W=16.
- Reset mid-operation discards any in-flight samples; no sample_valid is issued for them.
- Stage 1, on the ce_sample cycle N:
  - p[k] = ch_en[k] ? (ch_data[k]*ch_gain[k]) >> 3 : 0.
  - p[k] has width IN_W+GAIN_W-3; truncate, no rounding.
- Stage 2, cycle N+1: sum = Σp[k], with width SUM_W = IN_W+GAIN_W-3+clog2(NCH). The sum never overflows.
- Stage 3, cycle N+2:
  - If sum > 2^OUT_W-1: sample_out = all ones and clip is set.
  - Otherwise sample_out = sum[OUT_W-1:0].
  - sample_valid pulses high for one cycle.
- Latency: ce_sample to sample_valid is 3 cycles, counting cycle N as 0, so sample_valid rises at N+3.
- The pipeline is fully pipelined. Back-to-back ce_sample on consecutive cycles each produce a result 3 cycles later. No stalls, no backpressure.
- ce_sample low: stage registers hold their values and no sample_valid is issued.
- Gain 0 or a disabled channel contributes exactly 0.
- clip:
  - Sticky; cleared only by clip_clr or reset.
  - If clip_clr and a saturation happen in the same cycle, set wins and clip=1.
- Sigma-delta DAC:
  - Runs every clk_sys cycle, independent of ce_sample.
  - acc[OUT_W:0] <= {1'b0, acc[OUT_W-1:0]} + sample_out.
  - dac_o <= acc carry (bit OUT_W) of the new sum, registered.
  - Ones density equals sample_out/2^OUT_W.
  - sample_out=0 gives constant 0. sample_out = all ones gives 1 on every cycle except 1 in 2^OUT_W.

Optional Feature:
- Macro: AUDIO_MIX_DC_BLOCK_EN.
- Defined: a 4th pipeline stage applies a DC-blocking high-pass to the saturated sample:
  - y = x − x_prev + y_prev − (y_prev >>> 8), in signed OUT_W+2 arithmetic.
  - The result is saturated to signed OUT_W and re-biased to unsigned for sample_out.
  - Latency becomes 4 cycles.
  - Filter state resets to x_prev=0x8000-equivalent midpoint and y_prev=0.
- Undefined: no filter stage; latency is 3 cycles.

Decomposition:
- Package audio_mix_pkg holds:
  - localparams GAIN_FRAC=3 and GAIN_UNITY=8;
  - function sum_width(nch, in_w, gain_w);
  - DC-block coefficient shift DCB_SHIFT=8.
- One sub-module: sd_dac1 (parameter W). It holds the first-order sigma-delta accumulator and the registered dac_o, and is reused by other cores.

Test Plan:
All scenarios use the default parameters.
- Unity single channel: ch0=0x3FFF, gain 8, others disabled, one ce_sample → sample_valid at +3 cycles, sample_out=0x3FFF, clip=0.
- Four channels at full scale, gain 8 → sample_out=0xFFFC, clip=0.
- Four channels at 0x3FFF, gain 15 (each p=0x77FE, sum 0x1DFF8) → sample_out=0xFFFF, clip=1. clip stays 1 after inputs drop to 0; clip_clr pulse clears it.
- Back-to-back ce_sample on 3 consecutive cycles with ch0 values 0x0001/0x0002/0x0003 → three consecutive sample_valid pulses carrying 1, 2, 3 in order.
- Hold sample_out=0x8000 for 256 cycles after the DAC warms up → exactly 128 ones on dac_o, alternating; sample_out=0 → dac_o constantly 0.
- Assert reset 1 cycle after ce_sample → no sample_valid follows; all outputs at their reset values on the next edge; sample_s=0x8000.
